// File: rtl/imem_fetch_responder.sv
// Instruction-fetch responder: serves 32-bit instructions from a one-entry doubleword
// buffer and refills it from instruction memory over a variable-latency req/ack bus.
module imem_fetch_responder #(
    parameter int                ADDR_W   = 64,
    parameter int                INST_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] inst_addr_i,
    input  logic              inst_ena_i,
    output logic [INST_W-1:0] inst_o,
    output logic              inst_valid_o,
    output logic              inst_fault_o,
    output logic              stall_req_o,
    input  logic              flush_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [63:0]       mem_rdata_i,
    input  logic              mem_err_i
);

    typedef enum logic {IDLE, WAIT} state_e;

    state_e            state_q;
    logic              mem_req_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [ADDR_W-4:0] buf_tag_q;
    logic [63:0]       buf_data_q;
    logic              buf_valid_q;
    logic              buf_fault_q;
    logic              drop_q;

    logic hit;
    logic misalign;
    logic start_miss;
    logic fill;

    assign misalign   = (inst_addr_i[1:0] != 2'b00);
    assign hit        = buf_valid_q && (buf_tag_q == inst_addr_i[ADDR_W-1:3]) && (state_q == IDLE);
    assign start_miss = (state_q == IDLE) && inst_ena_i && !misalign && !hit && !flush_i;
    // A flush arriving with the ack poisons the returning data just like an earlier flush.
    assign fill       = (state_q == WAIT) && mem_ack_i && !drop_q && !flush_i;

    assign mem_req_o  = mem_req_q;
    assign mem_addr_o = mem_addr_q;

    always_comb begin
        inst_o       = NOP_INST;
        inst_valid_o = 1'b0;
        inst_fault_o = 1'b0;
        stall_req_o  = 1'b0;
        if (!inst_ena_i) begin
            inst_valid_o = 1'b0;
        end else if (misalign) begin
            inst_valid_o = 1'b1;
            inst_fault_o = 1'b1;
        end else if (hit && !buf_fault_q) begin
            inst_valid_o = 1'b1;
            inst_o       = inst_addr_i[2] ? buf_data_q[63:32] : buf_data_q[31:0];
        end else if (hit) begin
            inst_valid_o = 1'b1;
            inst_fault_o = 1'b1;
        end else begin
            stall_req_o = 1'b1;
        end
    end

    // The request is never abandoned once issued; only reset can leave WAIT early.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            buf_tag_q   <= '0;
            buf_data_q  <= '0;
            buf_valid_q <= 1'b0;
            buf_fault_q <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_miss) begin
                        state_q    <= WAIT;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= {inst_addr_i[ADDR_W-1:3], 3'b000};
                    end
                end
                WAIT: begin
                    if (flush_i) begin
                        drop_q <= 1'b1;
                    end
                    if (mem_ack_i) begin
                        if (fill) begin
                            buf_tag_q   <= mem_addr_q[ADDR_W-1:3];
                            buf_data_q  <= mem_rdata_i;
                            buf_fault_q <= mem_err_i;
                            buf_valid_q <= 1'b1;
                        end
                        mem_req_q <= 1'b0;
                        drop_q    <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (flush_i) begin
                buf_valid_q <= 1'b0;
                buf_fault_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Bench for imem_fetch_responder: hand-written timing sequences followed by a table of
// fetches served by an auto-responding memory model and checked through a scoreboard.
module tb_imem_fetch_responder;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [63:0] addr;
        int          delay;
        logic        err;
        int          expFills;
        logic        expFault;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic        fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] instAddr = '0;
    logic        instEna = 1'b0;
    logic [31:0] inst;
    logic        instValid;
    logic        instFault;
    logic        stallReq;
    logic        flush = 1'b0;
    logic        memReq;
    logic [63:0] memAddr;
    logic        memAck = 1'b0;
    logic [63:0] memRdata = '0;
    logic        memErr = 1'b0;

    int   checkCount = 0;
    int   passCount = 0;
    int   fillCount = 0;
    int   ackDelay = 0;
    logic errNext = 1'b0;
    logic autoMem = 1'b0;
    exp_t sb[$];
    vec_t vecs[13];

    imem_fetch_responder dut (
        .clk          (clk),
        .rst          (rst),
        .inst_addr_i  (instAddr),
        .inst_ena_i   (instEna),
        .inst_o       (inst),
        .inst_valid_o (instValid),
        .inst_fault_o (instFault),
        .stall_req_o  (stallReq),
        .flush_i      (flush),
        .mem_req_o    (memReq),
        .mem_addr_o   (memAddr),
        .mem_ack_i    (memAck),
        .mem_rdata_i  (memRdata),
        .mem_err_i    (memErr)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] memModel(input logic [63:0] dwAddr);
        return {dwAddr[31:0] ^ 32'h5A5A_5A5A, dwAddr[31:0] + 32'h0100_0001};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sampleNow();
        @(negedge clk);
    endtask

    // Memory model: acks ackDelay cycles after mem_req is first seen, only when enabled.
    initial begin
        int waitCnt;
        waitCnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (autoMem) begin
                if (memAck) begin
                    memAck  = 1'b0;
                    memErr  = 1'b0;
                    waitCnt = 0;
                end else if (memReq) begin
                    if (waitCnt >= ackDelay) begin
                        memAck   = 1'b1;
                        memRdata = memModel(memAddr);
                        memErr   = errNext;
                        fillCount++;
                    end else begin
                        waitCnt++;
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input int idx, input vec_t v);
        exp_t        e;
        exp_t        got;
        logic [63:0] data;
        int          fillsBefore;
        data    = memModel({v.addr[63:3], 3'b000});
        e.fault = v.expFault;
        e.inst  = v.expFault ? NOP : (v.addr[2] ? data[63:32] : data[31:0]);
        sb.push_back(e);
        nextCycle();
        fillsBefore = fillCount;
        ackDelay    = v.delay;
        errNext     = v.err;
        instAddr    = v.addr;
        instEna     = 1'b1;
        for (int c = 0; c < 40; c++) begin
            sampleNow();
            if (instValid) break;
            nextCycle();
        end
        checkOutput($sformatf("vec%0d_valid", idx), {63'd0, instValid}, 64'd1);
        got.inst  = inst;
        got.fault = instFault;
        e = sb.pop_front();
        checkOutput($sformatf("vec%0d_inst", idx), {32'd0, got.inst}, {32'd0, e.inst});
        checkOutput($sformatf("vec%0d_fault", idx), {63'd0, got.fault}, {63'd0, e.fault});
        checkOutput($sformatf("vec%0d_fills", idx), 64'(fillCount - fillsBefore), 64'(v.expFills));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{64'h0000_0000_0000_0100, 0, 1'b0, 1, 1'b0};
        vecs[1]  = '{64'h0000_0000_0000_0104, 0, 1'b0, 0, 1'b0};
        vecs[2]  = '{64'h0000_0000_0000_0100, 0, 1'b0, 0, 1'b0};
        vecs[3]  = '{64'h0000_0000_0000_010A, 0, 1'b0, 0, 1'b1};
        vecs[4]  = '{64'h0000_0000_0000_0108, 2, 1'b0, 1, 1'b0};
        vecs[5]  = '{64'h0000_0000_0000_010C, 0, 1'b0, 0, 1'b0};
        vecs[6]  = '{64'h0000_0000_0000_0200, 1, 1'b1, 1, 1'b1};
        vecs[7]  = '{64'h0000_0000_0000_0204, 0, 1'b0, 0, 1'b1};
        vecs[8]  = '{64'h0000_0000_0000_0208, 4, 1'b0, 1, 1'b0};
        vecs[9]  = '{64'h0000_0000_0000_0100, 0, 1'b0, 1, 1'b0};
        vecs[10] = '{64'hFFFF_FFFF_FFFF_FFFC, 1, 1'b0, 1, 1'b0};
        vecs[11] = '{64'hFFFF_FFFF_FFFF_FFF8, 0, 1'b0, 0, 1'b0};
        vecs[12] = '{64'h0000_0000_0000_0103, 0, 1'b0, 0, 1'b1};

        nextCycle();
        nextCycle();
        sampleNow();
        checkOutput("rst_inst", {32'd0, inst}, {32'd0, NOP});
        checkOutput("rst_valid", {63'd0, instValid}, 64'd0);
        checkOutput("rst_fault", {63'd0, instFault}, 64'd0);
        checkOutput("rst_stall", {63'd0, stallReq}, 64'd0);
        checkOutput("rst_memReq", {63'd0, memReq}, 64'd0);
        checkOutput("rst_memAddr", memAddr, 64'd0);

        // Cold miss with the ack in the first request cycle.
        nextCycle();
        rst = 1'b0; instEna = 1'b1; instAddr = 64'h1000;
        sampleNow();
        checkOutput("t1_stall_c0", {63'd0, stallReq}, 64'd1);
        nextCycle();
        memAck = 1'b1; memRdata = 64'hAAAA_BBBB_CCCC_DDDD;
        sampleNow();
        checkOutput("t1_stall_c1", {63'd0, stallReq}, 64'd1);
        checkOutput("t1_memReq", {63'd0, memReq}, 64'd1);
        checkOutput("t1_memAddr", memAddr, 64'h1000);
        nextCycle();
        memAck = 1'b0;
        sampleNow();
        checkOutput("t1_inst", {32'd0, inst}, 64'hCCCC_DDDD);
        checkOutput("t1_valid", {63'd0, instValid}, 64'd1);
        checkOutput("t1_stall_c2", {63'd0, stallReq}, 64'd0);

        // Second word of the same doubleword, then the next doubleword.
        nextCycle();
        instAddr = 64'h1004;
        sampleNow();
        checkOutput("t2_inst", {32'd0, inst}, 64'hAAAA_BBBB);
        checkOutput("t2_memReq", {63'd0, memReq}, 64'd0);
        nextCycle();
        instAddr = 64'h1008;
        sampleNow();
        checkOutput("t2_miss_stall", {63'd0, stallReq}, 64'd1);
        nextCycle();
        memAck = 1'b1; memRdata = 64'h1111_2222_3333_4444;
        sampleNow();
        checkOutput("t2_memReq", {63'd0, memReq}, 64'd1);
        checkOutput("t2_memAddr", memAddr, 64'h1008);
        nextCycle();
        memAck = 1'b0;
        sampleNow();
        checkOutput("t2_fill_inst", {32'd0, inst}, 64'h3333_4444);

        // Delayed ack while the PC wanders away during WAIT.
        nextCycle();
        instAddr = 64'h2004;
        sampleNow();
        checkOutput("t3_stall", {63'd0, stallReq}, 64'd1);
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            if (i == 1) instAddr = 64'h3000;
            if (i == 3) begin
                memAck = 1'b1; memRdata = 64'h2222_0004_2222_0000;
            end
            sampleNow();
            checkOutput($sformatf("t3_memReq_%0d", i), {63'd0, memReq}, 64'd1);
            checkOutput($sformatf("t3_memAddr_%0d", i), memAddr, 64'h2000);
        end
        nextCycle();
        memAck = 1'b0; instAddr = 64'h2004;
        sampleNow();
        checkOutput("t3_tag_hit_inst", {32'd0, inst}, 64'h2222_0004);
        checkOutput("t3_tag_hit_valid", {63'd0, instValid}, 64'd1);
        nextCycle();
        instAddr = 64'h3000;
        sampleNow();
        checkOutput("t3_3000_stall", {63'd0, stallReq}, 64'd1);
        nextCycle();
        memAck = 1'b1; memRdata = 64'h3333_0004_3333_0000;
        sampleNow();
        checkOutput("t3_3000_memAddr", memAddr, 64'h3000);
        nextCycle();
        memAck = 1'b0;
        sampleNow();
        checkOutput("t3_3000_inst", {32'd0, inst}, 64'h3333_0000);

        // Bus error fill becomes a sticky faulted entry.
        nextCycle();
        instAddr = 64'h4000;
        sampleNow();
        checkOutput("t4_stall", {63'd0, stallReq}, 64'd1);
        nextCycle();
        memAck = 1'b1; memErr = 1'b1; memRdata = 64'hDEAD_BEEF_DEAD_BEEF;
        sampleNow();
        checkOutput("t4_memAddr", memAddr, 64'h4000);
        nextCycle();
        memAck = 1'b0; memErr = 1'b0;
        sampleNow();
        checkOutput("t4_valid", {63'd0, instValid}, 64'd1);
        checkOutput("t4_fault", {63'd0, instFault}, 64'd1);
        checkOutput("t4_inst", {32'd0, inst}, {32'd0, NOP});
        nextCycle();
        sampleNow();
        checkOutput("t4_refetch_memReq", {63'd0, memReq}, 64'd0);
        checkOutput("t4_refetch_fault", {63'd0, instFault}, 64'd1);

        // Misaligned PC faults immediately.
        nextCycle();
        instAddr = 64'h5002;
        sampleNow();
        checkOutput("t5_valid", {63'd0, instValid}, 64'd1);
        checkOutput("t5_fault", {63'd0, instFault}, 64'd1);
        checkOutput("t5_stall", {63'd0, stallReq}, 64'd0);
        checkOutput("t5_inst", {32'd0, inst}, {32'd0, NOP});
        nextCycle();
        sampleNow();
        checkOutput("t5_memReq", {63'd0, memReq}, 64'd0);

        // Flush during WAIT discards the returning data.
        nextCycle();
        instAddr = 64'h6000;
        sampleNow();
        checkOutput("t6_stall", {63'd0, stallReq}, 64'd1);
        nextCycle();
        flush = 1'b1;
        sampleNow();
        checkOutput("t6_flush_memReq", {63'd0, memReq}, 64'd1);
        nextCycle();
        flush = 1'b0; memAck = 1'b1; memRdata = 64'h6666_0004_6666_0000;
        sampleNow();
        checkOutput("t6_held_memReq", {63'd0, memReq}, 64'd1);
        nextCycle();
        memAck = 1'b0;
        sampleNow();
        checkOutput("t6_dropped_stall", {63'd0, stallReq}, 64'd1);
        checkOutput("t6_dropped_valid", {63'd0, instValid}, 64'd0);
        nextCycle();
        sampleNow();
        checkOutput("t6_refetch_memReq", {63'd0, memReq}, 64'd1);
        checkOutput("t6_refetch_memAddr", memAddr, 64'h6000);

        // Reset during WAIT, then a late ack that must be ignored.
        nextCycle();
        rst = 1'b1;
        sampleNow();
        nextCycle();
        rst = 1'b0; instEna = 1'b0; memAck = 1'b1; memRdata = 64'h6666_0004_6666_0000;
        sampleNow();
        checkOutput("t6_rst_memReq", {63'd0, memReq}, 64'd0);
        nextCycle();
        memAck = 1'b0; instEna = 1'b1; instAddr = 64'h6000;
        sampleNow();
        checkOutput("t6_late_ack_stall", {63'd0, stallReq}, 64'd1);
        checkOutput("t6_late_ack_valid", {63'd0, instValid}, 64'd0);

        // Flush coinciding with the ack also discards the data.
        nextCycle();
        flush = 1'b1; memAck = 1'b1; memRdata = 64'h7777_0004_7777_0000;
        sampleNow();
        checkOutput("t6_same_memReq", {63'd0, memReq}, 64'd1);
        nextCycle();
        flush = 1'b0; memAck = 1'b0;
        sampleNow();
        checkOutput("t6_same_stall", {63'd0, stallReq}, 64'd1);
        checkOutput("t6_same_idle_memReq", {63'd0, memReq}, 64'd0);
        nextCycle();
        memAck = 1'b1;
        sampleNow();
        nextCycle();
        memAck = 1'b0; instEna = 1'b0; flush = 1'b1;
        sampleNow();
        checkOutput("ena_off_inst", {32'd0, inst}, {32'd0, NOP});
        checkOutput("ena_off_valid", {63'd0, instValid}, 64'd0);
        nextCycle();
        flush = 1'b0;
        autoMem = 1'b1;

        for (int i = 0; i < 13; i++) begin
            applyStimulus(i, vecs[i]);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/imem_fetch_responder.md
Name: imem_fetch_responder

Overview:
Responder side of the instruction-fetch interface. Accepts the fetch stage's instruction address and enable, and returns a 32-bit instruction word combinationally on a hit. On a miss it raises a stall and fetches the aligned 64-bit doubleword from the instruction memory over a req/ack bus with variable latency. A one-entry doubleword buffer serves both instructions in each fetched doubleword, and faults are reported for misaligned addresses and memory errors.

Parameters:
ADDR_W, 64, fetch and memory address width
INST_W, 32, instruction width
NOP_INST, 32'h0000_0013, value driven on inst when no valid instruction (addi x0,x0,0)

Ports:
clk  in  1  clock
rst  in  1  reset
inst_addr  in  ADDR_W  fetch PC from IF stage
inst_ena  in  1  fetch request valid
inst  out  INST_W  instruction for inst_addr
inst_valid  out  1  inst is valid this cycle
inst_fault  out  1  fetch fault (misaligned or memory error); qualifies inst_valid
stall_req  out  1  fetch not satisfiable this cycle; IF must hold PC
flush  in  1  invalidate buffer (fence.i / redirect)
mem_req  out  1  memory read request
mem_addr  out  ADDR_W  doubleword address, bits [2:0]=0
mem_ack  in  1  read data/err valid, one-cycle pulse
mem_rdata  in  64  read data
mem_err  in  1  bus error, sampled with mem_ack

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - Reset values: state=IDLE, mem_req=0, mem_addr=0, buf_valid=0, buf_fault=0, drop=0.
  - Combinational outputs follow from this state: inst=NOP_INST, inst_valid=0, inst_fault=0, stall_req=0 (with inst_ena=0).
- Buffer fields: buf_tag (inst_addr[ADDR_W-1:3]), buf_data[63:0], buf_valid, buf_fault.
- hit = buf_valid && buf_tag==inst_addr[ADDR_W-1:3] && state==IDLE.
- misalign = inst_addr[1:0]!=0.
- Combinational output priority:
  - inst_ena=0: inst_valid=0, inst_fault=0, stall_req=0, inst=NOP_INST.
  - misalign: inst_valid=1, inst_fault=1, stall_req=0, inst=NOP_INST. No memory request is issued.
  - hit && !buf_fault: inst_valid=1, inst_fault=0, stall_req=0. inst = inst_addr[2] ? buf_data[63:32] : buf_data[31:0].
  - hit && buf_fault: inst_valid=1, inst_fault=1, stall_req=0, inst=NOP_INST.
  - otherwise: inst_valid=0, stall_req=1, inst=NOP_INST.
- FSM, two states:
  - IDLE: if inst_ena && !misalign && !hit && !flush, then next cycle mem_req=1, mem_addr={inst_addr[ADDR_W-1:3],3'b000}, state=WAIT.
  - WAIT: mem_req and mem_addr are held stable until mem_ack.
    - On mem_ack && !drop: buf_tag=mem_addr[ADDR_W-1:3], buf_data=mem_rdata, buf_fault=mem_err, buf_valid=1.
    - On any mem_ack: mem_req=0, drop=0, state=IDLE.
    - The hit is visible the cycle after ack.
- Miss latency: miss in cycle N; mem_req rises in N+1; if ack arrives in N+1+k (k>=0), inst_valid=1 in N+2+k.
- inst_addr changing during WAIT does not alter mem_addr. The fill completes with the latched address, then IDLE re-evaluates and may miss again.
- flush:
  - In IDLE: buf_valid=0 next cycle; a request is not started in the flush cycle.
  - In WAIT: the outstanding request still completes (no abandon), but drop=1, so returned data is discarded and buf_valid stays 0.
  - flush and mem_ack in the same cycle: data is discarded.
- mem_ack while in IDLE is ignored.
- Reset mid-WAIT returns to reset state immediately. The memory side must tolerate an abandoned request; the late ack is ignored in IDLE.
- A faulted buffer entry persists until it is replaced by another fill or cleared by flush/rst.

Test Plan:
1. Cold miss, ack k=0:
   - Stimulus: rst then inst_ena=1, addr=0x1000 at cycle 0; ack at cycle 1 with rdata=0xAAAA_BBBB_CCCC_DDDD.
   - Required: stall_req=1 in cycles 0-1; mem_req=1 and mem_addr=0x1000 in cycle 1; cycle 2 inst=0xCCCC_DDDD, inst_valid=1, stall_req=0.
2. Same-doubleword hit:
   - Stimulus: after test 1, addr=0x1004.
   - Required: inst=0xAAAA_BBBB same cycle, no mem_req.
   - Stimulus: then addr=0x1008.
   - Required: miss, mem_addr=0x1008.
3. Delayed ack:
   - Stimulus: miss at 0x2004, ack 3 cycles after mem_req, with inst_addr changed to 0x3000 during WAIT.
   - Required: mem_req and mem_addr=0x2000 stable for 4 cycles; buffer filled with tag for 0x2000; 0x3000 then misses.
4. Memory error:
   - Stimulus: ack with mem_err=1 for 0x4000.
   - Required: next cycle inst_valid=1, inst_fault=1, inst=0x00000013; refetch of 0x4000 issues no mem_req.
5. Misaligned:
   - Stimulus: addr=0x5002, inst_ena=1.
   - Required: same cycle inst_valid=1, inst_fault=1, stall_req=0; mem_req stays 0.
6. Flush and reset during WAIT:
   - Stimulus: flush asserted in WAIT.
   - Required: ack data is discarded, buf_valid=0, the same address misses again.
   - Stimulus: rst in WAIT.
   - Required: mem_req=0 next cycle; a late ack is ignored.
